inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage directly upstream of the `cpu` core: holds a loadable word-addressed program memory and a program counter, and presents one 32-bit MIPS instruction per cycle on `inst`, which drives the core's instruction input. It handles start, stall, branch/jump redirect and program termination. Program loading and the start strobe come from the bench or a future loader.

## Interface
- `ADDR_W`, 6, word-address width; memory depth is 2**ADDR_W words.
- `HALT_WORD`, 32'hFC00_0000, opcode 111111; fetching this word terminates the program.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_en`  in  1  write `load_data` to `load_addr`; honoured only in IDLE or HALT.
- `load_addr`  in  ADDR_W  program write address.
- `load_data`  in  32  program write data.
- `start`  in  1  begin fetching at word 0; honoured only in IDLE or HALT.
- `stall`  in  1  hold the current instruction.
- `redirect`  in  1  next fetch comes from `redirect_pc`.
- `redirect_pc`  in  ADDR_W  redirect target, word address.
- `inst`  out  32  current instruction, to the core.
- `inst_valid`  out  1  `inst` is a real instruction.
- `pc`  out  ADDR_W  word address of `inst`.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is HALT.
- `fetch_count`  out  16  instructions presented since the last start; saturates at 16'hFFFF.

## Operation
- States are IDLE, RUN and HALT. On reset: state IDLE, `inst`=0, `inst_valid`=0, `pc`=0, `fetch_count`=0, `done`=0, `busy`=0. Reset does not clear memory.
- IDLE/HALT with `start`:
  - fetch mem[0].
  - If mem[0]==HALT_WORD, go to HALT with `inst_valid`=0.
  - Otherwise go to RUN with `inst`=mem[0], `pc`=0, `inst_valid`=1, `fetch_count`=1.
- `start` in RUN is ignored.
- RUN advance priority, evaluated each cycle:
  - `redirect`: target = `redirect_pc`. Redirect overrides `stall`.
  - else `stall`: hold `inst`, `pc`, `inst_valid` and `fetch_count`.
  - else target = `pc`+1.
- For a target address:
  - If mem[target]==HALT_WORD, go to HALT with `inst_valid`=0 and `inst`=0.
  - If `pc`==2**ADDR_W-1 and the advance is non-redirect, go to HALT. There is no wrap-around.
  - Otherwise load `inst`=mem[target], set `pc`=target and increment `fetch_count`.
- HALT: `done`=1 and `inst_valid`=0; `pc` holds the last presented address.
- `load_en` in RUN is dropped silently; memory is unchanged.
- `load_en` and `start` in the same IDLE cycle: the write commits first, and the fetch of word 0 sees the new data if `load_addr`==0.
- The HALT_WORD comparison is done on the memory read data, never on `inst`.

## Timing
- The start-to-first-`inst_valid` latency is 1 cycle. Each non-stalled RUN cycle presents a new `inst` the following cycle.
- A redirect asserted in cycle N places mem[`redirect_pc`] on `inst` in cycle N+1. No bubble is inserted.
- A stall asserted in cycle N keeps `inst` identical in cycle N+1.
- All outputs are registered; no input has a combinational path to any output.
- A reset asserted mid-RUN returns the block to the reset values on the next edge.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants (ADDI 6'b001000, R-type 6'b000000, HALT 6'b111111);
  - the default HALT_WORD;
  - the fetch state encoding (IDLE, RUN, HALT).
- One sub-module, `inst_mem`: a 2**ADDR_W x 32 array with a synchronous write port and a combinational read port addressed by the target address.
- The state machine and PC live in `inst_fetch`, which registers the read data into `inst`.

## Test plan
- Load [0]=addi $1,$0,1 (32'h2001_0001), [1]=addi $2,$0,1 (32'h2002_0001), [2]=add $1,$1,$1 (32'h0021_0820), [3]=HALT_WORD, then pulse `start` -> `inst` sequence 2001_0001, 2002_0001, 0021_0820 with `pc` 0,1,2, followed by `done`=1, `inst_valid`=0 and `fetch_count`=3.
- Same program with `stall` high for 3 cycles while `pc`=1 -> `inst` held at 32'h2002_0001 for 4 cycles, and `fetch_count` does not advance.
- `redirect`=1 with `redirect_pc`=0 while `pc`=2, asserted together with `stall` -> next cycle `pc`=0 and `inst`=32'h2001_0001.
- Fill all 64 words with 32'h0000_0020 and no HALT, then start -> `pc` runs 0..63, then HALT with `fetch_count`=64.
- Assert `reset` at `pc`=1 -> next cycle all outputs at reset values. A subsequent `start` replays from word 0 with the memory contents intact.
- `load_en` to address 2 during RUN -> `inst` at `pc`=2 is still the original word. In HALT, the same write followed by `start` fetches the new word.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared MIPS opcode constants, halt word and fetch state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [5:0]  c_op_rtype  = 6'b000000;
    localparam logic [5:0]  c_op_addi   = 6'b001000;
    localparam logic [5:0]  c_op_halt   = 6'b111111;

    localparam logic [31:0] c_halt_word = {c_op_halt, 26'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_mem.sv
// ============================================================================
//  Module      : inst_mem
//  Description : Word-addressed program store, synchronous write, combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [31:0] r_mem [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
//  Module      : inst_fetch
//  Description : Program counter, fetch FSM and registered instruction output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = c_halt_word
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [15:0]       fetch_count
);

    fetch_state_t      r_state, w_state_nxt;
    logic [31:0]       r_inst, w_inst_nxt;
    logic              r_valid, w_valid_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [15:0]       r_count, w_count_nxt;

    logic              w_mem_we;
    logic [31:0]       w_mem_rdata;
    logic [31:0]       w_rdata;
    logic              w_fire;
    logic              w_seq_adv;
    logic [ADDR_W-1:0] w_target;
    logic              w_stop;
    logic [ADDR_W-1:0] w_pc_base;
    logic [15:0]       w_count_base;

    assign w_mem_we = load_en && (r_state != ST_RUN);

    inst_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (w_target),
        .rdata (w_mem_rdata)
    );

    // A write landing on the fetched word this same cycle is forwarded so the
    // fetch observes the new contents.
    assign w_rdata = (w_mem_we && (load_addr == w_target)) ? load_data : w_mem_rdata;

    always_comb begin
        w_fire    = 1'b0;
        w_seq_adv = 1'b0;
        w_target  = '0;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    w_fire   = 1'b1;
                    w_target = redirect_pc;
                end else if (!stall) begin
                    w_fire    = 1'b1;
                    w_seq_adv = 1'b1;
                    w_target  = r_pc + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_fire = 1'b1;
                end
            end
        endcase
    end

    // Sequential advance off the last word ends the program instead of wrapping.
    assign w_stop       = (w_rdata == HALT_WORD) || (w_seq_adv && (r_pc == {ADDR_W{1'b1}}));
    assign w_pc_base    = (r_state == ST_RUN) ? r_pc    : '0;
    assign w_count_base = (r_state == ST_RUN) ? r_count : 16'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_inst_nxt  = r_inst;
        w_valid_nxt = r_valid;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        if (w_fire) begin
            if (w_stop) begin
                w_state_nxt = ST_HALT;
                w_inst_nxt  = 32'd0;
                w_valid_nxt = 1'b0;
                w_pc_nxt    = w_pc_base;
                w_count_nxt = w_count_base;
            end else begin
                w_state_nxt = ST_RUN;
                w_inst_nxt  = w_rdata;
                w_valid_nxt = 1'b1;
                w_pc_nxt    = w_target;
                w_count_nxt = (w_count_base == 16'hFFFF) ? w_count_base : w_count_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_inst  <= 32'd0;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_inst  <= w_inst_nxt;
            r_valid <= w_valid_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign inst        = r_inst;
    assign inst_valid  = r_valid;
    assign pc          = r_pc;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_HALT);
    assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Directed self-checking bench for inst_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    localparam logic [31:0] c_halt = 32'hFC00_0000;
    localparam logic [31:0] c_i0   = 32'h2001_0001;
    localparam logic [31:0] c_i1   = 32'h2002_0001;
    localparam logic [31:0] c_i2   = 32'h0021_0820;
    localparam logic [31:0] c_nop  = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  pc;
    logic        busy;
    logic        done;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    inst_fetch #(
        .ADDR_W    (6),
        .HALT_WORD (32'hFC00_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e_inst, input logic e_valid,
                              input logic [5:0] e_pc, input logic [15:0] e_cnt,
                              input logic e_busy, input logic e_done);
        chk({tag, ".inst"},  inst,                e_inst);
        chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
        chk({tag, ".pc"},    {26'd0, pc},         {26'd0, e_pc});
        chk({tag, ".count"}, {16'd0, fetch_count}, {16'd0, e_cnt});
        chk({tag, ".busy"},  {31'd0, busy},       {31'd0, e_busy});
        chk({tag, ".done"},  {31'd0, done},       {31'd0, e_done});
    endtask

    task automatic load_word(input logic [5:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        expect_out("reset", 32'd0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0);
        reset = 1'b0;

        load_word(6'd0, c_i0);
        load_word(6'd1, c_i1);
        load_word(6'd2, c_i2);
        load_word(6'd3, c_halt);
        expect_out("idle_after_load", 32'd0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0);

        // Basic program run
        start = 1'b1; step(); start = 1'b0;
        expect_out("run.pc0", c_i0, 1'b1, 6'd0, 16'd1, 1'b1, 1'b0);
        step();
        expect_out("run.pc1", c_i1, 1'b1, 6'd1, 16'd2, 1'b1, 1'b0);
        step();
        expect_out("run.pc2", c_i2, 1'b1, 6'd2, 16'd3, 1'b1, 1'b0);
        step();
        expect_out("run.halt", 32'd0, 1'b0, 6'd2, 16'd3, 1'b0, 1'b1);

        // Stall at pc=1 for three cycles, then redirect+stall at pc=2
        start = 1'b1; step(); start = 1'b0;
        expect_out("st.pc0", c_i0, 1'b1, 6'd0, 16'd1, 1'b1, 1'b0);
        step();
        expect_out("st.pc1", c_i1, 1'b1, 6'd1, 16'd2, 1'b1, 1'b0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("st.hold", c_i1, 1'b1, 6'd1, 16'd2, 1'b1, 1'b0);
        end
        stall = 1'b0; step();
        expect_out("st.pc2", c_i2, 1'b1, 6'd2, 16'd3, 1'b1, 1'b0);
        redirect = 1'b1; redirect_pc = 6'd0; stall = 1'b1; step();
        redirect = 1'b0; stall = 1'b0;
        expect_out("redir.pc0", c_i0, 1'b1, 6'd0, 16'd4, 1'b1, 1'b0);
        step();
        expect_out("redir.pc1", c_i1, 1'b1, 6'd1, 16'd5, 1'b1, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        expect_out("redir.start_ignored", c_i2, 1'b1, 6'd2, 16'd6, 1'b1, 1'b0);
        step();
        expect_out("redir.halt", 32'd0, 1'b0, 6'd2, 16'd6, 1'b0, 1'b1);

        // Reset mid-run, then replay with memory intact
        start = 1'b1; step(); start = 1'b0;
        step();
        expect_out("rst.pc1", c_i1, 1'b1, 6'd1, 16'd2, 1'b1, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        expect_out("rst.values", 32'd0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        expect_out("rst.replay0", c_i0, 1'b1, 6'd0, 16'd1, 1'b1, 1'b0);

        // Load during RUN is dropped
        load_en = 1'b1; load_addr = 6'd2; load_data = c_nop; step(); load_en = 1'b0;
        expect_out("ld_run.pc1", c_i1, 1'b1, 6'd1, 16'd2, 1'b1, 1'b0);
        step();
        expect_out("ld_run.pc2", c_i2, 1'b1, 6'd2, 16'd3, 1'b1, 1'b0);
        step();
        expect_out("ld_run.halt", 32'd0, 1'b0, 6'd2, 16'd3, 1'b0, 1'b1);

        // Load in HALT takes effect
        load_word(6'd2, c_nop);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        expect_out("ld_halt.pc2", c_nop, 1'b1, 6'd2, 16'd3, 1'b1, 1'b0);
        step();
        expect_out("ld_halt.halt", 32'd0, 1'b0, 6'd2, 16'd3, 1'b0, 1'b1);

        // Load to word 0 together with start: fetch sees new data
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h2003_0005; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        expect_out("ldst.pc0", 32'h2003_0005, 1'b1, 6'd0, 16'd1, 1'b1, 1'b0);
        step(); step(); step();
        expect_out("ldst.halt", 32'd0, 1'b0, 6'd2, 16'd3, 1'b0, 1'b1);

        // HALT_WORD at word 0 written alongside start: straight to HALT
        load_en = 1'b1; load_addr = 6'd0; load_data = c_halt; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        expect_out("halt0", 32'd0, 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);

        // Full memory with no HALT_WORD: run off the end
        for (int a = 0; a < 64; a++) begin
            load_word(a[5:0], c_nop);
        end
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("fill.pc",    {26'd0, pc},          i);
            chk("fill.count", {16'd0, fetch_count}, i + 1);
            chk("fill.inst",  inst,                 c_nop);
            step();
        end
        expect_out("fill.halt", 32'd0, 1'b0, 6'd63, 16'd64, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
